// File: rtl/tb_align_collector_pkg.sv
// Symbol codes, collector states and pair classification shared with the traceback stage.
package tb_align_collector_pkg;

    localparam logic [2:0] SYM_A    = 3'b000;
    localparam logic [2:0] SYM_C    = 3'b001;
    localparam logic [2:0] SYM_G    = 3'b010;
    localparam logic [2:0] SYM_T    = 3'b011;
    localparam logic [2:0] SYM_GAP  = 3'b100;
    localparam logic [2:0] SYM_IDLE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_MATCH,
        CLS_MISMATCH,
        CLS_GAP
    } pair_class_t;

    // Traceback drives IDLE on both symbols when it has nothing to say.
    function automatic logic pair_valid(input logic [2:0] r, input logic [2:0] q);
        return !((r == SYM_IDLE) && (q == SYM_IDLE));
    endfunction

    function automatic pair_class_t classify(input logic [2:0] r, input logic [2:0] q);
        if ((r == SYM_GAP) || (q == SYM_GAP)) begin
            return CLS_GAP;
        end
        if (r == q) begin
            return CLS_MATCH;
        end
        return CLS_MISMATCH;
    endfunction

endpackage

// File: rtl/tb_align_collector_if.sv
// Forward-order aligned pair stream with valid/ready handshake.
interface tb_align_collector_if;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_r;
    logic [2:0] out_q;
    logic       out_last;

    modport master (
        output out_valid,
        output out_r,
        output out_q,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_r,
        input  out_q,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/tb_align_collector_align_lifo.sv
// DEPTH x 6-bit stack of {r,q} pairs; exposes top and the entry beneath it for back-to-back pops.
module align_lifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [5:0]    push_data,
    input  logic          pop,
    output logic [5:0]    top,
    output logic [5:0]    second,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [5:0]    mem [DEPTH];
    logic [CW-1:0] count_reg;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] second_idx;
    logic          do_push;
    logic          do_pop;

    assign full       = (count_reg == CW'(DEPTH));
    assign empty      = (count_reg == '0);
    assign do_push    = push && !full && !clear;
    assign do_pop     = pop && !empty && !clear && !push;
    assign wr_idx     = AW'(count_reg);
    assign top_idx    = AW'(count_reg - CW'(1));
    assign second_idx = AW'(count_reg - CW'(2));

    // Storage carries no reset so it maps onto RAM; only the count is reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (do_push) begin
            count_reg <= count_reg + CW'(1);
        end else if (do_pop) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign top    = mem[top_idx];
    assign second = mem[second_idx];
    assign count  = count_reg;
endmodule

// File: rtl/tb_align_collector.sv
// Collects reverse-order traceback pairs, replays them forward over valid/ready and keeps alignment statistics.
module tb_align_collector
    import tb_align_collector_pkg::*;
#(
    parameter int L     = 8,
    parameter int DEPTH = 2 * L,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_traceback,
    input  logic [2:0]            in_r,
    input  logic [2:0]            in_q,
    input  logic                  tb_finish,
    tb_align_collector_if.master  stream,
    output logic [CW-1:0]         aln_len,
    output logic [CW-1:0]         match_cnt,
    output logic [CW-1:0]         mismatch_cnt,
    output logic [CW-1:0]         gap_cnt,
    output logic                  stats_valid,
    output logic                  overflow,
    output logic                  busy
);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);

    state_t        state_reg;
    logic          out_valid_reg;
    logic          out_last_reg;
    logic [2:0]    out_r_reg;
    logic [2:0]    out_q_reg;
    logic [CW-1:0] aln_len_reg;
    logic [CW-1:0] match_reg;
    logic [CW-1:0] mismatch_reg;
    logic [CW-1:0] gap_reg;
    logic          overflow_reg;

    logic [CW-1:0] lifo_count;
    logic          lifo_full;
    logic          lifo_empty;
    logic [5:0]    lifo_top;
    logic [5:0]    lifo_second;
    logic          in_valid;
    logic          push;
    logic          pop;
    logic          lifo_clear;

    assign in_valid   = pair_valid(in_r, in_q);
    assign push       = (state_reg == ST_COLLECT) && start_traceback && in_valid && !lifo_full;
    assign pop        = (state_reg == ST_DRAIN) && start_traceback && out_valid_reg && stream.out_ready;
    // Aborts and idle time both leave the stack empty for the next session.
    assign lifo_clear = (state_reg == ST_IDLE) || !start_traceback;

    align_lifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_lifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (lifo_clear),
        .push      (push),
        .push_data ({in_r, in_q}),
        .pop       (pop),
        .top       (lifo_top),
        .second    (lifo_second),
        .count     (lifo_count),
        .full      (lifo_full),
        .empty     (lifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_r_reg     <= SYM_IDLE;
            out_q_reg     <= SYM_IDLE;
            aln_len_reg   <= '0;
            match_reg     <= '0;
            mismatch_reg  <= '0;
            gap_reg       <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_traceback) begin
                        state_reg    <= ST_COLLECT;
                        aln_len_reg  <= '0;
                        match_reg    <= '0;
                        mismatch_reg <= '0;
                        gap_reg      <= '0;
                        overflow_reg <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (!start_traceback) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        if (in_valid) begin
                            if (lifo_full) begin
                                overflow_reg <= 1'b1;
                            end else begin
                                aln_len_reg <= aln_len_reg + ONE;
                                case (classify(in_r, in_q))
                                    CLS_GAP:   gap_reg      <= gap_reg + ONE;
                                    CLS_MATCH: match_reg    <= match_reg + ONE;
                                    default:   mismatch_reg <= mismatch_reg + ONE;
                                endcase
                            end
                        end
                        // The pair pushed on the finish edge is the new top, so bypass the stack.
                        if (tb_finish) begin
                            if (push) begin
                                state_reg     <= ST_DRAIN;
                                out_valid_reg <= 1'b1;
                                out_r_reg     <= in_r;
                                out_q_reg     <= in_q;
                                out_last_reg  <= lifo_empty;
                            end else if (!lifo_empty) begin
                                state_reg     <= ST_DRAIN;
                                out_valid_reg <= 1'b1;
                                {out_r_reg, out_q_reg} <= lifo_top;
                                out_last_reg  <= (lifo_count == ONE);
                            end else begin
                                state_reg <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!start_traceback) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        out_r_reg     <= SYM_IDLE;
                        out_q_reg     <= SYM_IDLE;
                    end else if (pop) begin
                        if (lifo_count > ONE) begin
                            {out_r_reg, out_q_reg} <= lifo_second;
                            out_last_reg <= (lifo_count == TWO);
                        end else begin
                            state_reg     <= ST_DONE;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_r_reg     <= SYM_IDLE;
                            out_q_reg     <= SYM_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!start_traceback) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign stream.out_valid = out_valid_reg;
    assign stream.out_last  = out_last_reg;
    assign stream.out_r     = out_r_reg;
    assign stream.out_q     = out_q_reg;
    assign aln_len          = aln_len_reg;
    assign match_cnt        = match_reg;
    assign mismatch_cnt     = mismatch_reg;
    assign gap_cnt          = gap_reg;
    assign overflow         = overflow_reg;
    assign stats_valid      = (state_reg == ST_DRAIN) || (state_reg == ST_DONE);
    assign busy             = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_tb_align_collector.sv
// Directed sessions against a queue-based model of the reverse-capture / forward-replay collector.
module tb_tb_align_collector;
    localparam int L     = 8;
    localparam int DEPTH = 2 * L;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_traceback = 1'b0;
    logic          tb_finish = 1'b0;
    logic [2:0]    in_r = 3'b111;
    logic [2:0]    in_q = 3'b111;
    logic [CW-1:0] aln_len, match_cnt, mismatch_cnt, gap_cnt;
    logic          stats_valid, overflow, busy;

    tb_align_collector_if ifc();

    tb_align_collector #(.L(L)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_traceback (start_traceback),
        .in_r            (in_r),
        .in_q            (in_q),
        .tb_finish       (tb_finish),
        .stream          (ifc),
        .aln_len         (aln_len),
        .match_cnt       (match_cnt),
        .mismatch_cnt    (mismatch_cnt),
        .gap_cnt         (gap_cnt),
        .stats_valid     (stats_valid),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [5:0] exp_q[$];
    logic [5:0] recv[$];
    int         m_len, m_match, m_mis, m_gap;
    int         m_ovf;
    bit         cmp_en = 0;
    bit         quiet = 0;
    bit         prev_stall = 0;
    int         ready_mode = 0;
    int         rphase = 0;
    logic [3:0] rpat = 4'b1001;
    logic [2:0] stim_r[32];
    logic [2:0] stim_q[32];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every presented pair must be the model's next forward pair.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (prev_stall) check("valid_hold", int'(ifc.out_valid), 1);
                if (quiet) check("quiet_valid", int'(ifc.out_valid), 0);
                if (ifc.out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("extra_pair", 1, 0);
                    end else begin
                        check("out_r", int'(ifc.out_r), int'(exp_q[0][5:3]));
                        check("out_q", int'(ifc.out_q), int'(exp_q[0][2:0]));
                        check("out_last", int'(ifc.out_last), int'(exp_q.size() == 1));
                        if (ifc.out_ready) begin
                            recv.push_back({ifc.out_r, ifc.out_q});
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (stats_valid) begin
                    check("aln_len", int'(aln_len), m_len);
                    check("match_cnt", int'(match_cnt), m_match);
                    check("mismatch_cnt", int'(mismatch_cnt), m_mis);
                    check("gap_cnt", int'(gap_cnt), m_gap);
                    check("overflow", int'(overflow), m_ovf);
                end
                prev_stall = ifc.out_valid && !ifc.out_ready;
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                ifc.out_ready = 1'b1;
            end else if (ready_mode == 1) begin
                ifc.out_ready = rpat[rphase];
                rphase = (rphase + 1) % 4;
            end
        end
    end

    task automatic load(input int idx, input logic [2:0] r, input logic [2:0] q);
        stim_r[idx] = r;
        stim_q[idx] = q;
    endtask

    // Stim arrays hold traceback order (bottom-right first); model output is the reverse.
    task automatic run_session(input int n, input int rmode);
        bit done;
        exp_q.delete();
        recv.delete();
        m_len = 0; m_match = 0; m_mis = 0; m_gap = 0; m_ovf = 0;
        for (int i = 0; i < n; i++) begin
            if (!(stim_r[i] == 3'b111 && stim_q[i] == 3'b111)) begin
                if (m_len == DEPTH) begin
                    m_ovf = 1;
                end else begin
                    exp_q.push_front({stim_r[i], stim_q[i]});
                    m_len++;
                    if (stim_r[i] == 3'b100 || stim_q[i] == 3'b100) m_gap++;
                    else if (stim_r[i] == stim_q[i]) m_match++;
                    else m_mis++;
                end
            end
        end
        ready_mode = rmode;
        if (rmode == 2) ifc.out_ready = 1'b0;
        @(posedge clk); #1;
        start_traceback = 1'b1; in_r = 3'b111; in_q = 3'b111; tb_finish = 1'b0;
        @(posedge clk); #1;
        check("clr_aln_len", int'(aln_len), 0);
        check("clr_match", int'(match_cnt), 0);
        check("clr_gap", int'(gap_cnt), 0);
        check("clr_overflow", int'(overflow), 0);
        check("busy_collect", int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            in_r = stim_r[i];
            in_q = stim_q[i];
            tb_finish = (i == n - 1);
            @(posedge clk); #1;
        end
        if (rmode != 2) begin
            done = 0;
            for (int c = 0; c < 200; c++) begin
                if (exp_q.size() == 0 && !ifc.out_valid && stats_valid) begin
                    done = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("drain_done", int'(done), 1);
        end
    endtask

    task automatic end_session();
        start_traceback = 1'b0; tb_finish = 1'b0; in_r = 3'b111; in_q = 3'b111;
        @(posedge clk); #1;
        check("busy_idle", int'(busy), 0);
        check("stats_idle", int'(stats_valid), 0);
    endtask

    initial begin
        ifc.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_valid", int'(ifc.out_valid), 0);
        check("rst_r", int'(ifc.out_r), 7);
        check("rst_q", int'(ifc.out_q), 7);
        check("rst_last", int'(ifc.out_last), 0);
        check("rst_aln_len", int'(aln_len), 0);
        check("rst_stats", int'(stats_valid), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        #19 rst = 1'b0;
        cmp_en = 1;

        // All-diagonal stream; forward order 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) load(i, 3'((7 - i) % 4), 3'((7 - i) % 4));
        run_session(8, 0);
        check("t1_recv_n", recv.size(), 8);
        for (int k = 0; k < recv.size(); k++) check("t1_fwd", int'(recv[k][5:3]), k % 4);
        check("t1_match", int'(match_cnt), 8);
        check("t1_len", int'(aln_len), 8);
        end_session();

        // Mixed stream with an idle sentinel in the middle.
        load(0, 3'd0, 3'd0); load(1, 3'd3, 3'd3); load(2, 3'd2, 3'd2);
        load(3, 3'd7, 3'd7); load(4, 3'd1, 3'd1); load(5, 3'd4, 3'd3);
        load(6, 3'd1, 3'd2); load(7, 3'd0, 3'd0); load(8, 3'd4, 3'd0);
        run_session(9, 0);
        check("t2_gap", int'(gap_cnt), 2);
        check("t2_mis", int'(mismatch_cnt), 1);
        check("t2_match", int'(match_cnt), 5);
        check("t2_len", int'(aln_len), 8);
        check("t2_first", int'(recv[0]), 32);
        check("t2_third", int'(recv[2]), 10);
        end_session();

        // Same stream under 1,0,0,1 backpressure.
        run_session(9, 1);
        check("t3_recv_n", recv.size(), 8);
        check("t3_gap", int'(gap_cnt), 2);
        end_session();

        // Overflow: 18 pushes into 16 entries.
        for (int i = 0; i < 18; i++) load(i, 3'(i % 4), (i % 5 == 0) ? 3'd4 : 3'(i % 4));
        run_session(18, 0);
        check("t4_len", int'(aln_len), 16);
        check("t4_ovf", int'(overflow), 1);
        check("t4_recv_n", recv.size(), 16);
        check("t4_gap", int'(gap_cnt), 4);
        check("t4_match", int'(match_cnt), 12);
        end_session();

        // Abort after 3 pairs: nothing may be presented.
        quiet = 1;
        exp_q.delete();
        ready_mode = 0;
        @(posedge clk); #1;
        start_traceback = 1'b1; in_r = 3'b111; in_q = 3'b111;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_r = 3'(i); in_q = 3'(i); tb_finish = 1'b0;
            @(posedge clk); #1;
        end
        check("t5_len", int'(aln_len), 3);
        start_traceback = 1'b0; in_r = 3'b111; in_q = 3'b111;
        @(posedge clk); #1;
        check("t5_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 quiet = 0;
        for (int i = 0; i < 8; i++) load(i, 3'((7 - i) % 4), 3'((7 - i) % 4));
        run_session(8, 0);
        check("t5_new_len", int'(aln_len), 8);
        end_session();

        // Asynchronous reset with 4 pairs still in the stack.
        run_session(8, 2);
        ifc.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 ifc.out_ready = 1'b0;
        check("t6_remaining", exp_q.size(), 4);
        #2;
        cmp_en = 0;
        rst = 1'b1;
        #1;
        check("t6_valid", int'(ifc.out_valid), 0);
        check("t6_r", int'(ifc.out_r), 7);
        check("t6_q", int'(ifc.out_q), 7);
        check("t6_aln_len", int'(aln_len), 0);
        check("t6_match", int'(match_cnt), 0);
        check("t6_stats", int'(stats_valid), 0);
        check("t6_busy", int'(busy), 0);
        start_traceback = 1'b0; tb_finish = 1'b0;
        #13 rst = 1'b0;
        @(posedge clk); #1;
        check("t6_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
